// File: rtl/pong_pkg.sv
// Shared Pong types and constants.
// State codes, screen geometry and the default miss line.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_MISS  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam int SCREEN_H   = 480;
  localparam int SCREEN_W   = 640;
  localparam int MISS_Y_DEF = SCREEN_H;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable frame-tick down-counter; stops at 0.
// Ports: clk, rst_n, load, load_val, frame_tick -> zero, last.
module pong_tick_timer
  import pong_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         frame_tick,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  // last: the next frame tick empties the counter
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/pong_game_controller.sv
// Pong game sequencer: serve, play, pause, miss, game over.
// Ports: clock/reset, frame_tick, start_btn, ball_y, score_counter
//        -> ball_run, ball_restart, lives, high_score, game_state.
module pong_game_controller
  import pong_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 180,
  parameter int MISS_Y      = MISS_Y_DEF
) (
  input  logic       Game_Clock,
  input  logic       Game_Reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] ball_y,
  input  logic [7:0] score_counter,
  output logic       ball_run,
  output logic       ball_restart,
  output logic [1:0] lives,
  output logic [7:0] high_score,
  output logic [2:0] game_state
);

  localparam int TW =
    $clog2(max2(SERVE_TICKS, OVER_TICKS) + 1);

  state_e       state_q, state_d;
  logic [1:0]   lives_q, lives_d;
  logic [7:0]   high_q, high_d;
  logic         run_q, run_d;
  logic         rst_q, rst_d;
  logic         prev_q;
  logic         start_edge;
  logic         tmr_load;
  logic [TW-1:0] tmr_val;
  logic         tmr_zero;
  logic         tmr_last;

  assign start_edge = start_btn && !prev_q;

  pong_tick_timer #(.W(TW)) u_timer (
    .clk        (Game_Clock),
    .rst_n      (Game_Reset_n),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .frame_tick (frame_tick),
    .zero       (tmr_zero),
    .last       (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    high_d   = high_q;
    rst_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(SERVE_TICKS);
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_SERVE;
          lives_d  = 2'(LIVES_INIT);
          rst_d    = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick && tmr_last) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // a miss outranks a pause request
        if (ball_y >= 10'(MISS_Y)) begin
          state_d = ST_MISS;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (score_counter > high_q) begin
            high_d = score_counter;
          end
        end else if (start_edge) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_edge) begin
          state_d = ST_PLAY;
        end
      end
      ST_MISS: begin
        tmr_load = 1'b1;
        if (lives_q == 2'd0) begin
          state_d = ST_OVER;
          tmr_val = TW'(OVER_TICKS);
        end else begin
          state_d = ST_SERVE;
          rst_d   = 1'b1;
        end
      end
      ST_OVER: begin
        if (start_edge && tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    run_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge Game_Clock or negedge Game_Reset_n) begin
    if (!Game_Reset_n) begin
      state_q <= ST_IDLE;
      lives_q <= 2'(LIVES_INIT);
      high_q  <= '0;
      run_q   <= 1'b0;
      rst_q   <= 1'b0;
      // held button through reset must not look like a press
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      high_q  <= high_d;
      run_q   <= run_d;
      rst_q   <= rst_d;
      prev_q  <= start_btn;
    end
  end

  assign ball_run     = run_q;
  assign ball_restart = rst_q;
  assign lives        = lives_q;
  assign high_score   = high_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Self-checking bench for pong_game_controller.
// Scoreboard of expected outputs, one entry per clock.
module tb_pong_game_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b1;
  logic [9:0] ball_y = '0;
  logic [7:0] score_counter = '0;
  logic       ball_run;
  logic       ball_restart;
  logic [1:0] lives;
  logic [7:0] high_score;
  logic [2:0] game_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lv;
    logic [7:0] hi;
    logic       run;
    logic       rs;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pong_game_controller #(
    .LIVES_INIT  (2),
    .SERVE_TICKS (3),
    .OVER_TICKS  (4),
    .MISS_Y      (480)
  ) dut (
    .Game_Clock    (clk),
    .Game_Reset_n  (rst_n),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .ball_y        (ball_y),
    .score_counter (score_counter),
    .ball_run      (ball_run),
    .ball_restart  (ball_restart),
    .lives         (lives),
    .high_score    (high_score),
    .game_state    (game_state)
  );

  function automatic exp_t obs();
    exp_t o;
    o.st  = game_state;
    o.lv  = lives;
    o.hi  = high_score;
    o.run = ball_run;
    o.rs  = ball_restart;
    return o;
  endfunction

  task automatic check(input string tag,
                       input exp_t got,
                       input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: st/lv/hi/run/rs got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
               tag, got.st, got.lv, got.hi, got.run, got.rs,
               want.st, want.lv, want.hi, want.run, want.rs);
    end
  endtask

  // drive one cycle of inputs at negedge, expect outputs after the edge
  task automatic cyc(input string tag,
                     input logic ft, input logic sb,
                     input int by, input int sc,
                     input int st, input int lv, input int hi,
                     input int run, input int rs);
    exp_t e;
    frame_tick    = ft;
    start_btn     = sb;
    ball_y        = 10'(by);
    score_counter = 8'(sc);
    e.st  = 3'(st);
    e.lv  = 2'(lv);
    e.hi  = 8'(hi);
    e.run = 1'(run);
    e.rs  = 1'(rs);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    check(tag_q.pop_front(), obs(), exp_q.pop_front());
  endtask

  initial begin
    exp_t r;
    r = '{st: 3'd0, lv: 2'd2, hi: 8'd0, run: 1'b0, rs: 1'b0};
    repeat (3) @(negedge clk);
    check("reset_hold", obs(), r);
    rst_n = 1'b1;
    // 1: held button gives no start
    cyc("held0", 0, 1, 0, 0, 0, 2, 0, 0, 0);
    cyc("held1", 0, 1, 0, 0, 0, 2, 0, 0, 0);
    cyc("release", 0, 0, 0, 0, 0, 2, 0, 0, 0);
    // 2: start and serve
    cyc("start", 0, 1, 0, 0, 1, 2, 0, 0, 1);
    cyc("rs_1cyc", 0, 1, 0, 0, 1, 2, 0, 0, 0);
    cyc("srv_t1", 1, 1, 0, 0, 1, 2, 0, 0, 0);
    cyc("srv_gap", 0, 1, 0, 0, 1, 2, 0, 0, 0);
    cyc("srv_t2", 1, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc("srv_edge", 0, 1, 0, 0, 1, 2, 0, 0, 0);
    cyc("srv_t3", 1, 1, 0, 0, 2, 2, 0, 1, 0);
    // 3: first miss
    cyc("play", 0, 1, 0, 7, 2, 2, 0, 1, 0);
    cyc("miss1", 0, 1, 480, 7, 4, 1, 7, 0, 0);
    cyc("reserve", 0, 1, 0, 7, 1, 1, 7, 0, 1);
    cyc("rs_t1", 1, 1, 0, 7, 1, 1, 7, 0, 0);
    cyc("rs_t2", 1, 1, 0, 7, 1, 1, 7, 0, 0);
    cyc("rs_t3", 1, 1, 0, 7, 2, 1, 7, 1, 0);
    // 5: pause
    cyc("play2", 0, 0, 0, 7, 2, 1, 7, 1, 0);
    cyc("pause", 0, 1, 0, 7, 3, 1, 7, 0, 0);
    cyc("pz_miss", 1, 1, 480, 7, 3, 1, 7, 0, 0);
    cyc("pz_tick", 1, 1, 479, 7, 3, 1, 7, 0, 0);
    cyc("pz_rel", 0, 0, 0, 7, 3, 1, 7, 0, 0);
    cyc("resume", 0, 1, 0, 7, 2, 1, 7, 1, 0);
    // 4: second miss, game over
    cyc("play3", 0, 0, 479, 5, 2, 1, 7, 1, 0);
    cyc("miss2", 0, 0, 480, 5, 4, 0, 7, 0, 0);
    cyc("over", 0, 0, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_e4", 0, 1, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_t1", 1, 0, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_e3", 1, 1, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_t3", 1, 0, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_t4", 1, 0, 0, 5, 5, 0, 7, 0, 0);
    cyc("ov_exit", 0, 1, 0, 5, 0, 0, 7, 0, 0);
    cyc("idle_rel", 0, 0, 0, 5, 0, 0, 7, 0, 0);
    cyc("newgame", 0, 1, 0, 5, 1, 2, 7, 0, 1);
    // 6: miss beats pause, then reset mid-serve
    cyc("ng_t1", 1, 1, 0, 5, 1, 2, 7, 0, 0);
    cyc("ng_t2", 1, 1, 0, 5, 1, 2, 7, 0, 0);
    cyc("ng_t3", 1, 1, 0, 5, 2, 2, 7, 1, 0);
    cyc("ng_rel", 0, 0, 0, 5, 2, 2, 7, 1, 0);
    cyc("miss_win", 0, 1, 480, 5, 4, 1, 7, 0, 0);
    cyc("serve3", 0, 0, 0, 5, 1, 1, 7, 0, 1);
    cyc("serve3b", 1, 0, 0, 5, 1, 1, 7, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst", obs(), r);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc("post_rst_t", 1, 0, 0, 0, 0, 2, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
